// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use detection.
// Define FORWARD_EN to enable EX/MEM and MEM/WB forwarding; otherwise operands come straight from the register file reads.
module id_ex_stage #(
  parameter int DW              = 32,
  parameter int SIZE_ALUCTRLOUT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       IdValid,
  input  logic [DW-1:0]              IdReadData1,
  input  logic [DW-1:0]              IdReadData2,
  input  logic [DW-1:0]              IdImm,
  input  logic                       IdAluSrc,
  input  logic [SIZE_ALUCTRLOUT:0]   IdAluCtrl,
  input  logic [4:0]                 IdShamt,
  input  logic [4:0]                 IdRs,
  input  logic [4:0]                 IdRt,
  input  logic [4:0]                 IdRd,
  input  logic                       IdRegWrite,
  input  logic                       IdMemRead,
  input  logic                       IdMemWrite,
  input  logic                       Stall,
  input  logic                       Flush,
  input  logic                       ExMemRegWrite,
  input  logic [4:0]                 ExMemRd,
  input  logic [DW-1:0]              ExMemAluRes,
  input  logic                       MemWbRegWrite,
  input  logic [4:0]                 MemWbRd,
  input  logic [DW-1:0]              MemWbData,
  output logic                       ExValid,
  output logic [DW-1:0]              InputData1,
  output logic [DW-1:0]              InputData2,
  output logic [SIZE_ALUCTRLOUT:0]   AluCtrlOut,
  output logic [4:0]                 Shamt,
  output logic [DW-1:0]              ExStoreData,
  output logic [4:0]                 ExRd,
  output logic                       ExRegWrite,
  output logic                       ExMemRead,
  output logic                       ExMemWrite,
  output logic                       LoadUseHazard
);

  logic                     valid_q, valid_d;
  logic [DW-1:0]            rd1_q, rd1_d;
  logic [DW-1:0]            rd2_q, rd2_d;
  logic [DW-1:0]            imm_q, imm_d;
  logic                     alusrc_q, alusrc_d;
  logic [SIZE_ALUCTRLOUT:0] aluctrl_q, aluctrl_d;
  logic [4:0]               shamt_q, shamt_d;
  logic [4:0]               rs_q, rs_d;
  logic [4:0]               rt_q, rt_d;
  logic [4:0]               rd_q, rd_d;
  logic                     regwrite_q, regwrite_d;
  logic                     memread_q, memread_d;
  logic                     memwrite_q, memwrite_d;
  logic [DW-1:0]            fwd_a, fwd_b;

  // Flush beats Stall; a load with IdValid=0 degenerates into the same bubble.
  always_comb begin
    valid_d    = valid_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    aluctrl_d  = aluctrl_q;
    shamt_d    = shamt_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    if (Flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end else if (!Stall) begin
      valid_d    = IdValid;
      rd1_d      = IdReadData1;
      rd2_d      = IdReadData2;
      imm_d      = IdImm;
      alusrc_d   = IdAluSrc;
      aluctrl_d  = IdAluCtrl;
      shamt_d    = IdShamt;
      rs_d       = IdRs;
      rt_d       = IdRt;
      rd_d       = IdRd;
      regwrite_d = IdValid & IdRegWrite;
      memread_d  = IdValid & IdMemRead;
      memwrite_d = IdValid & IdMemWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= '0;
      shamt_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      aluctrl_q  <= aluctrl_d;
      shamt_q    <= shamt_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

`ifdef FORWARD_EN
  // EX/MEM is the younger result, so it wins; r0 is hardwired and never forwarded.
  always_comb begin
    fwd_a = rd1_q;
    if (ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == rs_q))
      fwd_a = ExMemAluRes;
    else if (MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == rs_q))
      fwd_a = MemWbData;
  end

  always_comb begin
    fwd_b = rd2_q;
    if (ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == rt_q))
      fwd_b = ExMemAluRes;
    else if (MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == rt_q))
      fwd_b = MemWbData;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ExMemRegWrite, ExMemRd, ExMemAluRes,
                        MemWbRegWrite, MemWbRd, MemWbData, rs_q, rt_q};
  assign fwd_a = rd1_q;
  assign fwd_b = rd2_q;
`endif

  assign ExValid     = valid_q;
  assign InputData1  = fwd_a;
  assign InputData2  = alusrc_q ? imm_q : fwd_b;
  assign ExStoreData = fwd_b;
  assign AluCtrlOut  = aluctrl_q;
  assign Shamt       = shamt_q;
  assign ExRd        = rd_q;
  assign ExRegWrite  = valid_q & regwrite_q;
  assign ExMemRead   = valid_q & memread_q;
  assign ExMemWrite  = valid_q & memwrite_q;

  assign LoadUseHazard = ExValid & ExMemRead & (ExRd != 5'd0) &
                         ((ExRd == IdRs) | (ExRd == IdRt));

endmodule
